i2c_target_regfile: RTL and testbench
=====================================

I2C_TARGET_REGFILE -- requirements
Module: i2c_target_regfile

Interface
REQ-001 The block SHALL provide parameter P_DEV_ADDR, default 7'b1000001, the 7-bit I2C device address it answers to.
REQ-002 The block SHALL provide parameter P_MEM_DEPTH, default 16, the number of 8-bit registers (power of two, 2..256).
REQ-003 The block SHALL provide port aclk, input, 1, the system clock; one clock only, frequency at least 8x SCL.
REQ-004 The block SHALL provide port aresetn, input, 1, the reset; asynchronous assert, active-low.
REQ-005 The block SHALL provide port SCL_I, input, 1, the sampled SCL bus line.
REQ-006 The block SHALL provide ports SCL_O and SCL_T, output, 1 each, tied to 0 and 1 (SCL never driven, no clock stretching).
REQ-007 The block SHALL provide port SDA_I, input, 1, the sampled SDA bus line.
REQ-008 The block SHALL provide port SDA_O, output, 1, the SDA drive value, constant 0.
REQ-009 The block SHALL provide port SDA_T, output, 1, the SDA tristate enable; 1 releases the line, 0 pulls it low.
REQ-010 The block SHALL provide port usr_addr, input, log2(P_MEM_DEPTH), the local read index.
REQ-011 The block SHALL provide port usr_rdata, output, 8, the combinational value of mem[usr_addr].
REQ-012 The block SHALL provide port usr_wr_pulse, output, 1, a one-cycle pulse on each I2C-side register write.

Function
REQ-013 SCL_I and SDA_I SHALL each pass through a 2-flop synchronizer; all edges are detected on the synchronized values against a third registered copy.
REQ-014 START SHALL be SDA falling while SCL high; STOP SHALL be SDA rising while SCL high; both take priority over data bits in the same cycle.
REQ-015 Bits SHALL be sampled, MSB first, on the synchronized SCL rising edge.
REQ-016 SDA_T changes SHALL occur only in the cycle after a synchronized SCL falling edge.
REQ-017 The state machine SHALL have states IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
REQ-018 START from any state, including a repeated START, SHALL enter DEV_ADDR with the bit counter cleared; STOP from any state SHALL enter IDLE with SDA released.
REQ-019 On the 8th bit, if addr[7:1]==P_DEV_ADDR, the FSM SHALL go to DEV_ACK and pull SDA low for the 9th clock; on mismatch it SHALL go to IDLE and leave SDA released.
REQ-020 After DEV_ACK: R/W=0 SHALL go to REG_ADDR; R/W=1 SHALL go to RD_DATA.
REQ-021 On completion of REG_ADDR, the pointer SHALL load byte mod P_MEM_DEPTH, and the block SHALL ACK (REG_ACK) and move to WR_DATA.
REQ-022 On the 8th bit in WR_DATA, mem[ptr] SHALL be written and usr_wr_pulse SHALL assert one cycle later.
REQ-023 After each written byte the block SHALL ACK (WR_ACK) and increment ptr, wrapping P_MEM_DEPTH-1 to 0.
REQ-024 On entry to RD_DATA, the shift register SHALL load mem[ptr] and ptr SHALL increment with wrap.
REQ-025 In RD_DATA, SDA_T SHALL equal the current bit; SDA SHALL be released for the 9th clock (RD_ACK).
REQ-026 In RD_ACK, sampled SDA=0 (ACK) SHALL go to RD_DATA; SDA=1 (NACK) SHALL go to IDLE with SDA released.
REQ-027 A write to register index >= P_MEM_DEPTH SHALL wrap by truncation; no error is signalled.

Reset
REQ-028 During reset: state=IDLE, ptr=0, all mem=8'h00, SDA_T=1, SDA_O=0, SCL_T=1, SCL_O=0, usr_wr_pulse=0, synchronizers=1.
REQ-029 Reset asserted mid-transfer SHALL release SDA immediately, without waiting for aclk.

Structure
REQ-030 Package i2c_target_pkg SHALL hold the FSM state enum and the ACK/NACK and R/W bit constants.
REQ-031 A sub-module i2c_line_sync SHALL implement the synchronizer plus START/STOP/rise/fall detection, one instance serving both lines.

Verification
REQ-032 Write: S 0x82 A 0x03 A 0xA5 A P -> three ACKs, mem[3]=0xA5, one usr_wr_pulse.
REQ-033 Random read: S 0x82 0x03 Sr 0x83, master NACK, P -> byte read is 0xA5; the block releases SDA after the NACK.
REQ-034 Wrong address: S 0x84 -> SDA stays released on the 9th clock; a following transfer is unaffected.
REQ-035 Burst wrap: write 0x0E with 0x11,0x22,0x33 -> mem[14]=0x11, mem[15]=0x22, mem[0]=0x33; three pulses.
REQ-036 STOP after 4 data bits -> IDLE, no write; aresetn low mid-read -> SDA_T=1 asynchronously, mem cleared.

Source files
------------

// File: rtl/i2c_target_pkg.sv
// Shared types and bus-level constants for the I2C target register file.
package i2c_target_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV_ADDR,
        ST_DEV_ACK,
        ST_REG_ADDR,
        ST_REG_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK
    } state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Double-flop synchronizer for SCL/SDA plus edge, START and STOP detection.
module i2c_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    // [1:0] form the synchronizer, [2] is the previous synchronized value.
    logic [2:0] scl_q;
    logic [2:0] sda_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], scl_i};
            sda_q <= {sda_q[1:0], sda_i};
        end
    end

    assign sda_o      = sda_q[1];
    assign scl_rise_o = scl_q[1] & ~scl_q[2];
    assign scl_fall_o = ~scl_q[1] & scl_q[2];
    assign start_o    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
    assign stop_o     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target exposing P_MEM_DEPTH byte registers with auto-incrementing pointer;
// the local side reads the array combinationally and sees a pulse per bus write.
module i2c_target_regfile
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] P_DEV_ADDR  = 7'b1000001,
    parameter int         P_MEM_DEPTH = 16
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic                           SCL_I,
    output logic                           SCL_O,
    output logic                           SCL_T,
    input  logic                           SDA_I,
    output logic                           SDA_O,
    output logic                           SDA_T,
    input  logic [$clog2(P_MEM_DEPTH)-1:0] usr_addr,
    output logic [7:0]                     usr_rdata,
    output logic                           usr_wr_pulse
);

    localparam int             AW      = $clog2(P_MEM_DEPTH);
    localparam logic [AW-1:0]  PTR_ONE = 1;

    logic          sda_s;
    logic          scl_rise;
    logic          scl_fall;
    logic          start_det;
    logic          stop_det;

    state_t        state_q;
    logic [AW-1:0] ptr_q;
    logic [7:0]    shift_q;
    logic [2:0]    bit_cnt_q;
    logic          sda_t_q;
    logic          wr_pulse_q;
    logic [7:0]    mem_q [P_MEM_DEPTH];
    logic [7:0]    byte_in;

    i2c_line_sync u_line_sync (
        .clk        (aclk),
        .rst_n      (aresetn),
        .scl_i      (SCL_I),
        .sda_i      (SDA_I),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_det),
        .stop_o     (stop_det)
    );

    // Byte as it stands once the bit arriving on this SCL rise is included.
    assign byte_in = {shift_q[6:0], sda_s};

    // Bits are captured on SCL rise; SDA only ever changes on the following SCL fall.
    // NOTE: the register array is reset explicitly because its power-up contents are architecturally visible.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            sda_t_q    <= 1'b1;
            wr_pulse_q <= 1'b0;
            for (int i = 0; i < P_MEM_DEPTH; i++) mem_q[i] <= 8'h00;
        end else begin
            wr_pulse_q <= 1'b0;
            if (start_det) begin
                state_q   <= ST_DEV_ADDR;
                bit_cnt_q <= '0;
                sda_t_q   <= 1'b1;
            end else if (stop_det) begin
                state_q <= ST_IDLE;
                sda_t_q <= 1'b1;
            end else if (scl_rise) begin
                case (state_q)
                    ST_DEV_ADDR: begin
                        shift_q   <= byte_in;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7)
                            state_q <= (byte_in[7:1] == P_DEV_ADDR) ? ST_DEV_ACK : ST_IDLE;
                    end
                    ST_REG_ADDR: begin
                        shift_q   <= byte_in;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            ptr_q   <= byte_in[AW-1:0];
                            state_q <= ST_REG_ACK;
                        end
                    end
                    ST_WR_DATA: begin
                        shift_q   <= byte_in;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            mem_q[ptr_q] <= byte_in;
                            ptr_q        <= ptr_q + PTR_ONE;
                            wr_pulse_q   <= 1'b1;
                            state_q      <= ST_WR_ACK;
                        end
                    end
                    ST_DEV_ACK: begin
                        bit_cnt_q <= '0;
                        if (shift_q[0] == RW_READ) begin
                            shift_q <= mem_q[ptr_q];
                            ptr_q   <= ptr_q + PTR_ONE;
                            state_q <= ST_RD_DATA;
                        end else begin
                            state_q <= ST_REG_ADDR;
                        end
                    end
                    ST_REG_ACK, ST_WR_ACK: begin
                        bit_cnt_q <= '0;
                        state_q   <= ST_WR_DATA;
                    end
                    ST_RD_DATA: begin
                        shift_q   <= {shift_q[6:0], 1'b0};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_q <= ST_RD_ACK;
                    end
                    ST_RD_ACK: begin
                        bit_cnt_q <= '0;
                        if (sda_s == I2C_ACK) begin
                            shift_q <= mem_q[ptr_q];
                            ptr_q   <= ptr_q + PTR_ONE;
                            state_q <= ST_RD_DATA;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: ;
                endcase
            end else if (scl_fall) begin
                case (state_q)
                    ST_DEV_ACK, ST_REG_ACK, ST_WR_ACK: sda_t_q <= I2C_ACK;
                    ST_RD_DATA:                        sda_t_q <= shift_q[7];
                    default:                           sda_t_q <= 1'b1;
                endcase
            end
        end
    end

    assign SCL_O        = 1'b0;
    assign SCL_T        = 1'b1;
    assign SDA_O        = 1'b0;
    assign SDA_T        = sda_t_q;
    assign usr_rdata    = mem_q[usr_addr];
    assign usr_wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench: bit-banged I2C master against the register file, open-drain SDA model.
module tb_i2c_target_regfile;

    localparam time Q = 50ns;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       SCL_O, SCL_T, SDA_O, SDA_T;
    logic [3:0] usr_addr = 4'd0;
    logic [7:0] usr_rdata;
    logic       usr_wr_pulse;

    int n_pass = 0;
    int n_total = 0;
    int pulse_cnt = 0;

    logic       ack;
    logic [7:0] rd;

    assign sda_line = sda_m & (SDA_T | SDA_O);

    i2c_target_regfile dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .SCL_I        (scl_m),
        .SCL_O        (SCL_O),
        .SCL_T        (SCL_T),
        .SDA_I        (sda_line),
        .SDA_O        (SDA_O),
        .SDA_T        (SDA_T),
        .usr_addr     (usr_addr),
        .usr_rdata    (usr_rdata),
        .usr_wr_pulse (usr_wr_pulse)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) if (usr_wr_pulse) pulse_cnt++;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_mem(input string tag, input logic [3:0] idx, input logic [7:0] exp);
        usr_addr = idx;
        #10;
        check(tag, usr_rdata, exp);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b1; #Q;
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; #Q;
        scl_m = 1'b1; #(2*Q);
        scl_m = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic a);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        a = sda_line; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic read_byte(input logic master_nack, output logic [7:0] d);
        sda_m = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #Q;
            scl_m = 1'b1; #Q;
            d = {d[6:0], sda_line}; #Q;
            scl_m = 1'b0;
        end
        #Q;
        sda_m = master_nack; #Q;
        scl_m = 1'b1; #(2*Q);
        scl_m = 1'b0; #Q;
        sda_m = 1'b1;
    endtask

    initial begin
        #22;
        check("rst_sda_t", 8'(SDA_T), 8'h1);
        check("rst_sda_o", 8'(SDA_O), 8'h0);
        check("rst_scl_t", 8'(SCL_T), 8'h1);
        check("rst_scl_o", 8'(SCL_O), 8'h0);
        check("rst_pulse", 8'(usr_wr_pulse), 8'h0);
        check_mem("rst_mem3", 4'd3, 8'h00);
        aresetn = 1'b1;
        #(2*Q);

        // Single write of 0xA5 to register 3
        i2c_start();
        write_byte(8'h82, ack); check("wr_dev_ack", 8'(ack), 8'h0);
        write_byte(8'h03, ack); check("wr_reg_ack", 8'(ack), 8'h0);
        write_byte(8'hA5, ack); check("wr_dat_ack", 8'(ack), 8'h0);
        i2c_stop();
        check_mem("wr_mem3", 4'd3, 8'hA5);
        check("wr_pulses", 8'(pulse_cnt), 8'd1);

        // Random read with repeated START, master NACK
        i2c_start();
        write_byte(8'h82, ack);
        write_byte(8'h03, ack);
        i2c_start();
        write_byte(8'h83, ack); check("rd_dev_ack", 8'(ack), 8'h0);
        read_byte(1'b1, rd);
        check("rd_data", rd, 8'hA5);
        check("rd_release", 8'(SDA_T), 8'h1);
        i2c_stop();

        // Wrong device address, then a normal write
        i2c_start();
        write_byte(8'h84, ack); check("bad_addr_nack", 8'(ack), 8'h1);
        i2c_stop();
        i2c_start();
        write_byte(8'h82, ack); check("post_bad_ack", 8'(ack), 8'h0);
        write_byte(8'h05, ack);
        write_byte(8'h5A, ack);
        i2c_stop();
        check_mem("post_bad_mem5", 4'd5, 8'h5A);
        check("post_bad_pulses", 8'(pulse_cnt), 8'd2);

        // Burst write wrapping from 14 through 0
        i2c_start();
        write_byte(8'h82, ack);
        write_byte(8'h0E, ack);
        write_byte(8'h11, ack);
        write_byte(8'h22, ack);
        write_byte(8'h33, ack); check("burst_last_ack", 8'(ack), 8'h0);
        i2c_stop();
        check_mem("burst_mem14", 4'd14, 8'h11);
        check_mem("burst_mem15", 4'd15, 8'h22);
        check_mem("burst_mem0", 4'd0, 8'h33);
        check("burst_pulses", 8'(pulse_cnt), 8'd5);

        // Burst read across the wrap point, ACK then NACK
        i2c_start();
        write_byte(8'h82, ack);
        write_byte(8'h0F, ack);
        i2c_start();
        write_byte(8'h83, ack);
        read_byte(1'b0, rd); check("rdburst_b0", rd, 8'h22);
        read_byte(1'b1, rd); check("rdburst_b1", rd, 8'h33);
        check("rdburst_release", 8'(SDA_T), 8'h1);
        i2c_stop();

        // Register index above depth truncates: 0x13 -> 3
        i2c_start();
        write_byte(8'h82, ack);
        write_byte(8'h13, ack);
        write_byte(8'h77, ack);
        i2c_stop();
        check_mem("trunc_mem3", 4'd3, 8'h77);
        check("trunc_pulses", 8'(pulse_cnt), 8'd6);

        // STOP after four data bits: no write
        i2c_start();
        write_byte(8'h82, ack);
        write_byte(8'h01, ack);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
        i2c_stop();
        check_mem("short_mem1", 4'd1, 8'h00);
        check("short_pulses", 8'(pulse_cnt), 8'd6);

        // Read from register 1 (0x00): target drives SDA low, then reset mid-byte
        i2c_start();
        write_byte(8'h83, ack); check("rst_rd_ack", 8'(ack), 8'h0);
        check("rst_rd_drive", 8'(SDA_T), 8'h0);
        aresetn = 1'b0;
        #1;
        check("async_release", 8'(SDA_T), 8'h1);
        #9;
        scl_m = 1'b1;
        sda_m = 1'b1;
        check_mem("rst_clr_mem3", 4'd3, 8'h00);
        check_mem("rst_clr_mem14", 4'd14, 8'h00);
        aresetn = 1'b1;
        #(2*Q);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
